ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 126 ++++++++++++
 tb/tb_ex_mem_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with condition-code evaluation and the committed
// {N,Z,C,V} flag register. Squashed instructions keep their data but lose
// their control bits; flushes insert a bubble while holding the data fields.
module ex_mem_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter logic [3:0]  FLAG_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              carry_out,
  input  logic              z,
  input  logic              n,
  input  logic              v,
  input  logic              s_bit,
  input  logic [3:0]        cond,
  input  logic [3:0]        rd_in,
  input  logic              reg_wr_in,
  input  logic              mem_rd_in,
  input  logic              mem_wr_in,
  input  logic [DATA_W-1:0] store_data_in,
  output logic [DATA_W-1:0] alu_out_q,
  output logic [DATA_W-1:0] store_data_q,
  output logic [3:0]        rd_q,
  output logic              reg_wr_q,
  output logic              mem_rd_q,
  output logic              mem_wr_q,
  output logic              valid_q,
  output logic [3:0]        flags_q,
  output logic              cond_pass,
  output logic              carry_in_o
);

  localparam int unsigned FLAG_W = 4;

  logic              flag_n, flag_z, flag_c, flag_v;
  logic [DATA_W-1:0] alu_out_d;
  logic [DATA_W-1:0] store_data_d;
  logic [3:0]        rd_d;
  logic              reg_wr_d;
  logic              mem_rd_d;
  logic              mem_wr_d;
  logic              valid_d;
  logic [FLAG_W-1:0] flags_d;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign carry_in_o = flags_q[1];

  // Condition decode against the committed flags only
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = ~flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = ~flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = ~flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = ~flag_v;
      4'h8: cond_pass = flag_c & ~flag_z;
      4'h9: cond_pass = ~flag_c | flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = ~flag_z & (flag_n == flag_v);
      4'hD: cond_pass = flag_z | (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Next-state: flush bubbles the controls, stall holds, otherwise load
  always_comb begin
    alu_out_d    = alu_out_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    reg_wr_d     = reg_wr_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    valid_d      = valid_q;
    flags_d      = flags_q;
    if (flush) begin
      reg_wr_d = 1'b0;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      valid_d  = 1'b0;
    end else if (!stall) begin
      alu_out_d    = alu_out;
      store_data_d = store_data_in;
      rd_d         = rd_in;
      reg_wr_d     = reg_wr_in & cond_pass;
      mem_rd_d     = mem_rd_in & cond_pass;
      mem_wr_d     = mem_wr_in & cond_pass;
      valid_d      = cond_pass;
      if (s_bit && cond_pass) begin
        flags_d = {n, z, carry_out, v};
      end
    end
  end

  // Pipeline and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_q    <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      valid_q      <= 1'b0;
      flags_q      <= FLAG_RST;
    end else begin
      alu_out_q    <= alu_out_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      reg_wr_q     <= reg_wr_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      valid_q      <= valid_d;
      flags_q      <= flags_d;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a sequential vector table with an expected-output
// queue, followed by a full cond x flags sweep of cond_pass.
module tb_ex_mem_stage;

  logic        clk;
  logic        reset, stall, flush;
  logic [31:0] alu_out, store_data_in;
  logic        carry_out, z, n, v, s_bit;
  logic [3:0]  cond, rd_in;
  logic        reg_wr_in, mem_rd_in, mem_wr_in;
  logic [31:0] alu_out_q, store_data_q;
  logic [3:0]  rd_q, flags_q;
  logic        reg_wr_q, mem_rd_q, mem_wr_q, valid_q, cond_pass, carry_in_o;

  int total = 0;
  int bad   = 0;

  ex_mem_stage #(.DATA_W(32), .FLAG_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .alu_out(alu_out), .carry_out(carry_out), .z(z), .n(n), .v(v),
    .s_bit(s_bit), .cond(cond), .rd_in(rd_in),
    .reg_wr_in(reg_wr_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
    .store_data_in(store_data_in),
    .alu_out_q(alu_out_q), .store_data_q(store_data_q), .rd_q(rd_q),
    .reg_wr_q(reg_wr_q), .mem_rd_q(mem_rd_q), .mem_wr_q(mem_wr_q),
    .valid_q(valid_q), .flags_q(flags_q), .cond_pass(cond_pass),
    .carry_in_o(carry_in_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, fls, s;
    logic [3:0]  cnd, nzcv;
    logic [31:0] alu, sd;
    logic [3:0]  rd;
    logic        rw, mr, mw;
    logic        chk_cp, e_cp;
    logic [31:0] e_alu, e_sd;
    logic [3:0]  e_rd;
    logic        e_rw, e_mr, e_mw, e_val;
    logic [3:0]  e_flags;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] alu, sd;
    logic [3:0]  rd;
    logic        rw, mr, mw, val;
    logic [3:0]  flags;
  } exp_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  exp_t exp_q [$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, req);
    end
  endtask

  // Reference condition evaluator: even codes give a base test, odd codes invert it
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic fn, fz, fc, fv, base;
    logic [2:0] sel;
    {fn, fz, fc, fv} = f;
    sel = c[3:1];
    case (sel)
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc & ~fz;
      3'd5: base = (fn == fv);
      3'd6: base = ~fz & (fn == fv);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic drive(input vec_t t);
    reset = t.rst; stall = t.stl; flush = t.fls; s_bit = t.s;
    cond = t.cnd; {n, z, carry_out, v} = t.nzcv;
    alu_out = t.alu; store_data_in = t.sd; rd_in = t.rd;
    reg_wr_in = t.rw; mem_rd_in = t.mr; mem_wr_in = t.mw;
  endtask

  initial begin
    exp_t e;
    //           rst  stl  fls  s    cnd   nzcv     alu            sd            rd    rw   mr   mw   chk  cp    e_alu          e_sd          e_rd  rw   mr   mw   val  flags
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b1,4'hE,4'b1111,32'hFFFF_FFFF,32'hFFFF_FFFF,4'hF,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,4'b0000};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,4'hE,4'b0000,32'h1234_5678,32'h0,        4'h3,1'b1,1'b0,1'b0,1'b1,1'b1,32'h1234_5678,32'h0,        4'h3,1'b1,1'b0,1'b0,1'b1,4'b0000};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,4'h0,4'b0000,32'hAAAA_0001,32'h55,       4'h5,1'b1,1'b0,1'b1,1'b1,1'b0,32'hAAAA_0001,32'h55,       4'h5,1'b0,1'b0,1'b0,1'b0,4'b0000};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,4'hE,4'b0110,32'h0,        32'h0,        4'h2,1'b1,1'b0,1'b0,1'b1,1'b1,32'h0,        32'h0,        4'h2,1'b1,1'b0,1'b0,1'b1,4'b0110};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,4'h0,4'b0000,32'h11,       32'h0,        4'h4,1'b1,1'b0,1'b0,1'b1,1'b1,32'h11,       32'h0,        4'h4,1'b1,1'b0,1'b0,1'b1,4'b0110};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,4'h1,4'b0000,32'h22,       32'h0,        4'h6,1'b1,1'b0,1'b0,1'b1,1'b0,32'h22,       32'h0,        4'h6,1'b0,1'b0,1'b0,1'b0,4'b0110};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,4'h1,4'b1000,32'h33,       32'h0,        4'h7,1'b1,1'b0,1'b0,1'b1,1'b0,32'h33,       32'h0,        4'h7,1'b0,1'b0,1'b0,1'b0,4'b0110};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,4'h2,4'b0000,32'h44,       32'h99,       4'h8,1'b0,1'b1,1'b0,1'b1,1'b1,32'h44,       32'h99,       4'h8,1'b0,1'b1,1'b0,1'b1,4'b0110};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b1,4'hE,4'b1001,32'h5555,     32'h0,        4'h9,1'b1,1'b0,1'b0,1'b1,1'b1,32'h44,       32'h99,       4'h8,1'b0,1'b1,1'b0,1'b1,4'b0110};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,4'h8,4'b0000,32'h6666,     32'h1,        4'hA,1'b0,1'b0,1'b1,1'b1,1'b0,32'h44,       32'h99,       4'h8,1'b0,1'b1,1'b0,1'b1,4'b0110};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b1,4'hA,4'b1111,32'h7777,     32'h2,        4'hB,1'b0,1'b0,1'b1,1'b1,1'b1,32'h44,       32'h99,       4'h8,1'b0,1'b1,1'b0,1'b1,4'b0110};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,4'hE,4'b1001,32'h5555,     32'h0,        4'h9,1'b1,1'b0,1'b0,1'b1,1'b1,32'h5555,     32'h0,        4'h9,1'b1,1'b0,1'b0,1'b1,4'b1001};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,4'h4,4'b0000,32'h8888,     32'h1234,     4'hC,1'b0,1'b0,1'b1,1'b1,1'b1,32'h8888,     32'h1234,     4'hC,1'b0,1'b0,1'b1,1'b1,4'b1001};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,4'hE,4'b0010,32'h1,        32'h0,        4'h1,1'b1,1'b0,1'b0,1'b1,1'b1,32'h1,        32'h0,        4'h1,1'b1,1'b0,1'b0,1'b1,4'b0010};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1,4'h2,4'b0001,32'h2,        32'h0,        4'h2,1'b1,1'b0,1'b0,1'b1,1'b1,32'h2,        32'h0,        4'h2,1'b1,1'b0,1'b0,1'b1,4'b0001};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,4'h6,4'b0000,32'h3,        32'h0,        4'h3,1'b1,1'b0,1'b0,1'b1,1'b1,32'h3,        32'h0,        4'h3,1'b1,1'b0,1'b0,1'b1,4'b0001};
    vecs[16] = '{1'b0,1'b1,1'b1,1'b1,4'hE,4'b1111,32'hDEAD,     32'hBEEF,     4'hE,1'b0,1'b0,1'b1,1'b1,1'b1,32'h3,        32'h0,        4'h3,1'b0,1'b0,1'b0,1'b0,4'b0001};
    vecs[17] = '{1'b0,1'b0,1'b1,1'b1,4'hE,4'b1100,32'hF00D,     32'h0,        4'h4,1'b1,1'b0,1'b0,1'b1,1'b1,32'h3,        32'h0,        4'h3,1'b0,1'b0,1'b0,1'b0,4'b0001};
    vecs[18] = '{1'b0,1'b0,1'b0,1'b0,4'hF,4'b0000,32'h77,       32'h66,       4'h5,1'b1,1'b0,1'b1,1'b1,1'b0,32'h77,       32'h66,       4'h5,1'b0,1'b0,1'b0,1'b0,4'b0001};
    vecs[19] = '{1'b1,1'b1,1'b1,1'b1,4'hE,4'b1111,32'hCAFE,     32'hCAFE,     4'h6,1'b1,1'b1,1'b1,1'b1,1'b1,32'h0,        32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,4'b0000};
    vecs[20] = '{1'b0,1'b0,1'b0,1'b0,4'h7,4'b0000,32'hA5,       32'h0,        4'h1,1'b1,1'b0,1'b0,1'b1,1'b1,32'hA5,       32'h0,        4'h1,1'b1,1'b0,1'b0,1'b1,4'b0000};

    drive(vecs[0]);

    // Table pass: drive on the falling edge, check cond_pass, queue the
    // expected post-edge state, then compare once the rising edge has passed
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      if (vecs[i].chk_cp) chk("cond_pass", i, 32'(cond_pass), 32'(vecs[i].e_cp));
      exp_q.push_back('{i, vecs[i].e_alu, vecs[i].e_sd, vecs[i].e_rd, vecs[i].e_rw,
                         vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_val, vecs[i].e_flags});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("queue_empty", i, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("alu_out_q",    e.idx, alu_out_q,          e.alu);
        chk("store_data_q", e.idx, store_data_q,       e.sd);
        chk("rd_q",         e.idx, 32'(rd_q),          32'(e.rd));
        chk("reg_wr_q",     e.idx, 32'(reg_wr_q),      32'(e.rw));
        chk("mem_rd_q",     e.idx, 32'(mem_rd_q),      32'(e.mr));
        chk("mem_wr_q",     e.idx, 32'(mem_wr_q),      32'(e.mw));
        chk("valid_q",      e.idx, 32'(valid_q),       32'(e.val));
        chk("flags_q",      e.idx, 32'(flags_q),       32'(e.flags));
        chk("carry_in_o",   e.idx, 32'(carry_in_o),    32'(e.flags[1]));
      end
    end

    // Sweep: load every flag value with an AL S-instruction, then try every cond
    for (int f = 0; f < 16; f++) begin
      @(negedge clk);
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      s_bit = 1'b1; cond = 4'hE; {n, z, carry_out, v} = 4'(f);
      reg_wr_in = 1'b0; mem_rd_in = 1'b0; mem_wr_in = 1'b0;
      @(posedge clk);
      #1;
      s_bit = 1'b0;
      chk("sweep_flags", f, 32'(flags_q), 32'(f));
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        chk("sweep_cond", f * 16 + c, 32'(cond_pass), 32'(ref_cond(4'(c), 4'(f))));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
